fft2d_out_streamer: RTL

- Downstream stage of FFT_2D. Captures the full N_POINT x N_POINT result matrix on the one-cycle data_tlast pulse.
- Serialises the captured matrix as a valid/ready word stream in column-major order: column p, rows 0..N_POINT-1, then p+1.
- Replaces the ad-hoc per-column output capture with a back-pressured, single-buffered output path for the next consumer (DMA/UART packer).
- Words are opaque 64-bit values; no arithmetic is applied.

---
 rtl/fft2d_out_streamer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fft2d_out_streamer.sv
// fft2d_out_streamer
// Captures a complete N_POINT x N_POINT FFT result matrix on the one-cycle
// frame_last pulse and replays it as a back-pressured valid/ready word stream.
// The replay order is column-major: column 0 rows 0..N-1, then column 1, and
// so on. A single buffer is used. A new frame is therefore accepted only
// while idle, or on the exact edge that hands over the final word. Any other
// frame_last is dropped and flagged on the sticky overrun output.
module fft2d_out_streamer #(
  parameter int N_POINT = 8,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(N_POINT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_POINT*N_POINT*DATA_W-1:0] frame_in,
  input  logic                          frame_last,
  output logic [DATA_W-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [IDX_W-1:0]              m_row,
  output logic [IDX_W-1:0]              m_col,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [CNT_W-1:0]              frame_cnt
);

  localparam int                WORDS   = N_POINT * N_POINT;
  localparam logic [IDX_W-1:0]  MAX_IDX = IDX_W'(N_POINT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state, state_nxt;
  logic [DATA_W-1:0]      frame_buf [WORDS];
  logic [IDX_W-1:0]       row_nxt, col_nxt;
  logic                   beat, last_beat, capture, drop;

  // Handshake and frame-acceptance qualifiers.
  assign m_tvalid  = (state == STREAM);
  assign busy      = m_tvalid;
  assign m_tlast   = m_tvalid && (m_row == MAX_IDX) && (m_col == MAX_IDX);
  assign beat      = m_tvalid & m_tready;
  assign last_beat = beat & m_tlast;
  assign capture   = frame_last & ((state == IDLE) | last_beat);
  assign drop      = frame_last & m_tvalid & ~last_beat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: enter STREAM on capture, leave after the final beat
  // unless a new frame is captured on that same edge.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = STREAM;
      STREAM:  if (last_beat && !frame_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column-major index advance: row first, column when the row wraps.
  always_comb begin
    row_nxt = m_row + IDX_W'(1);
    col_nxt = m_col;
    if (m_row == MAX_IDX) begin
      row_nxt = '0;
      col_nxt = m_col + IDX_W'(1);
    end
  end

  // Frame buffer: plain storage, written only on capture.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; its contents are only read after a capture.
    if (capture) begin
      for (int i = 0; i < WORDS; i++) begin
        frame_buf[i] <= frame_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output word and indices. The word is pre-fetched from the buffer at the
  // next index, so m_tdata stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_row   <= '0;
      m_col   <= '0;
      m_tdata <= '0;
    end else if (capture) begin
      m_row   <= '0;
      m_col   <= '0;
      m_tdata <= frame_in[DATA_W-1:0];
    end else if (beat) begin
      m_row <= row_nxt;
      m_col <= col_nxt;
      if (!m_tlast) m_tdata <= frame_buf[{row_nxt, col_nxt}];
    end
  end

  // Drained-frame counter and sticky overrun flag (a new drop beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      if (last_beat) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
